// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Covers the state encoding, the blank word and the requester/grant widths.
package seg_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int GID_W   = 2;

   // Every nibble is invalid BCD, so the scan driver shows nothing.
   localparam logic [31:0] BLANK_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;
endpackage

// File: rtl/seg_rr_pick.sv
// Combinational 4-way round-robin picker.
// Searches req starting at last+1, wrapping modulo NUM_REQ.
module seg_rr_pick
   import seg_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [GID_W-1:0]   last,
   output logic               found,
   output logic [GID_W-1:0]   idx
);
   logic [GID_W-1:0]   cand [NUM_REQ];
   logic [NUM_REQ-1:0] hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign cand[gi] = last + GID_W'(gi + 1);
         assign hit[gi]  = req[cand[gi]];
      end
   endgenerate

   // Scan from the lowest priority up so the nearest candidate wins.
   always_comb begin
      found = |hit;
      idx   = cand[0];
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (hit[k]) idx = cand[k];
      end
   end
endmodule

// File: rtl/seg_disp_arb.sv
// Round-robin arbiter sharing the 8-digit display between four page sources.
// Optional macro SEG_ARB_PREEMPT_EN lets requester 0 cut short another page.
module seg_disp_arb
   import seg_arb_pkg::*;
#(
   parameter int HOLD_CYCLES  = 50000000,
   parameter int BLANK_CYCLES = 5000000
) (
   input  logic                  seg_clk,
   input  logic                  seg_rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ack,
   output logic [31:0]           dsp_data,
   output logic [GID_W-1:0]      grant_id,
   output logic                  busy
);
   localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] BLANK_LD = (BLANK_CYCLES > 0) ? 32'(BLANK_CYCLES - 1) : 32'd0;

   state_t             state_reg, state_next;
   logic [31:0]        cnt_reg, cnt_next;
   logic [31:0]        dsp_reg, dsp_next;
   logic [GID_W-1:0]   gid_reg, gid_next;
   logic [GID_W-1:0]   last_reg, last_next;
   logic [NUM_REQ-1:0] ack_reg, ack_next;

   logic               pick_found;
   logic [GID_W-1:0]   pick_idx;
   logic               grant_en;
   logic [GID_W-1:0]   grant_idx;

   seg_rr_pick u_pick (
      .req   (req_valid),
      .last  (last_reg),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge seg_clk) begin
      if (!seg_rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         dsp_reg   <= BLANK_WORD;
         gid_reg   <= '0;
         last_reg  <= GID_W'(NUM_REQ - 1);
         ack_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dsp_reg   <= dsp_next;
         gid_reg   <= gid_next;
         last_reg  <= last_next;
         ack_reg   <= ack_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dsp_next   = dsp_reg;
      gid_next   = gid_reg;
      last_next  = last_reg;
      ack_next   = '0;
      grant_en   = 1'b0;
      grant_idx  = pick_idx;

      case (state_reg)
         IDLE: begin
            if (pick_found) grant_en = 1'b1;
         end
         SHOW: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 32'd1;
            end else if (!pick_found) begin
               state_next = IDLE;
            end else if (BLANK_CYCLES > 0) begin
               state_next = BLANK;
               dsp_next   = BLANK_WORD;
               cnt_next   = BLANK_LD;
            end else begin
               grant_en = 1'b1;
            end
         end
         BLANK: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 32'd1;
            end else if (pick_found) begin
               grant_en = 1'b1;
            end else begin
               state_next = IDLE;
               dsp_next   = BLANK_WORD;
            end
         end
         default: state_next = IDLE;
      endcase

`ifdef SEG_ARB_PREEMPT_EN
      // Requester 0 jumps the queue unless it already owns the display.
      if (req_valid[0] && ((state_reg == SHOW && gid_reg != '0) || state_reg == BLANK)) begin
         grant_en  = 1'b1;
         grant_idx = '0;
      end
`endif

      if (grant_en) begin
         ack_next   = NUM_REQ'(1) << grant_idx;
         dsp_next   = req_data[32*grant_idx +: 32];
         gid_next   = grant_idx;
         last_next  = grant_idx;
         cnt_next   = HOLD_LD;
         state_next = SHOW;
      end
   end

   assign req_ack  = ack_reg;
   assign dsp_data = dsp_reg;
   assign grant_id = gid_reg;
   assign busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_seg_disp_arb.sv
// Directed bench for seg_disp_arb with HOLD_CYCLES=8, BLANK_CYCLES=2.
// Expectations follow SEG_ARB_PREEMPT_EN when the bench is built with it.
module tb_seg_disp_arb;
   logic         seg_clk = 1'b0;
   logic         seg_rst_n;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_ack;
   logic [31:0]  dsp_data;
   logic [1:0]   grant_id;
   logic         busy;

   int vectors     = 0;
   int miscompares = 0;

   seg_disp_arb #(.HOLD_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .seg_clk   (seg_clk),
      .seg_rst_n (seg_rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ack   (req_ack),
      .dsp_data  (dsp_data),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 seg_clk = ~seg_clk;

   task automatic tick();
      @(posedge seg_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      seg_rst_n = 1'b0;
      req_valid = 4'b0000;
      repeat (3) tick();
      seg_rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      int blanks;
      logic ack_seen;
      logic [31:0] pages [4];
      pages[0] = 32'h1111_0000;
      pages[1] = 32'h2222_1111;
      pages[2] = 32'h3333_2222;
      pages[3] = 32'h4444_3333;
      req_data = '0;

      // Reset values
      do_reset();
      chk("rst_dsp",  dsp_data, 32'hFFFF_FFFF);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ack",  {28'd0, req_ack}, 32'd0);
      chk("rst_gid",  {30'd0, grant_id}, 32'd0);

      // Single request from IDLE
      tick();
      req_data[32*1 +: 32] = 32'h1234_5678;
      req_valid = 4'b0010;
      tick();
      chk("g1_ack",  {28'd0, req_ack}, 32'h2);
      chk("g1_dsp",  dsp_data, 32'h1234_5678);
      chk("g1_gid",  {30'd0, grant_id}, 32'd1);
      req_valid = 4'b0000;
      req_data[32*1 +: 32] = 32'hDEAD_BEEF;
      n = 1;
      tick();
      chk("g1_ack_pulse", {28'd0, req_ack}, 32'd0);
      while (busy && n < 30) begin
         n++;
         tick();
      end
      chk("g1_busy_len", n, 32'd8);
      chk("g1_retain",   dsp_data, 32'h1234_5678);

      // All four requesting: order 0,1,2,3 with 2-cycle blank gaps
      do_reset();
      for (int k = 0; k < 4; k++) req_data[32*k +: 32] = pages[k];
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         blanks = 0;
         tick();
         while (req_ack == 4'b0000 && n < 30) begin
            if (dsp_data == 32'hFFFF_FFFF) blanks++;
            tick();
            n++;
         end
         chk($sformatf("rr%0d_ack", k), {28'd0, req_ack}, 32'(4'b0001 << k));
         chk($sformatf("rr%0d_dsp", k), dsp_data, pages[k]);
         chk($sformatf("rr%0d_gid", k), {30'd0, grant_id}, 32'(k));
         if (k > 0) begin
            chk($sformatf("rr%0d_gap", k),   n, 32'd9);
            chk($sformatf("rr%0d_blank", k), blanks, 32'd2);
         end
         req_valid[k] = 1'b0;
      end
      wait_idle();
      chk("rr_retain", dsp_data, pages[3]);

      // Requester 2 re-requests on the exact expiry cycle
      req_data[32*2 +: 32] = 32'hAAAA_0002;
      req_valid = 4'b0100;
      tick();
      chk("ex_ack", {28'd0, req_ack}, 32'h4);
      req_valid = 4'b0000;
      repeat (7) tick();
      req_data[32*2 +: 32] = 32'hBBBB_0002;
      req_valid = 4'b0100;
      tick();
      chk("ex_blank_dsp", dsp_data, 32'hFFFF_FFFF);
      chk("ex_blank_busy", {31'd0, busy}, 32'd1);
      chk("ex_blank_ack", {28'd0, req_ack}, 32'd0);
      tick();
      tick();
      chk("ex_regrant_ack", {28'd0, req_ack}, 32'h4);
      chk("ex_regrant_dsp", dsp_data, 32'hBBBB_0002);

      // Requester 3 pending into BLANK, then withdrawn
      req_data[32*3 +: 32] = 32'hCCCC_0003;
      req_valid = 4'b1000;
      ack_seen = 1'b0;
      repeat (8) begin
         tick();
         ack_seen = ack_seen | (|req_ack);
      end
      chk("wd_blank_dsp", dsp_data, 32'hFFFF_FFFF);
      req_valid = 4'b0000;
      repeat (2) begin
         tick();
         ack_seen = ack_seen | (|req_ack);
      end
      chk("wd_no_ack", {31'd0, ack_seen}, 32'd0);
      chk("wd_idle",   {31'd0, busy}, 32'd0);
      chk("wd_dsp",    dsp_data, 32'hFFFF_FFFF);

      // Requester 0 arrives at cycle 3 of requester 1's page
      req_data[32*1 +: 32] = 32'hEEEE_0001;
      req_data[32*0 +: 32] = 32'hFFFF_0000 ^ 32'h0000_1234;
      req_valid = 4'b0010;
      tick();
      chk("pe_ack1", {28'd0, req_ack}, 32'h2);
      req_valid = 4'b0000;
      tick();
      tick();
      req_valid = 4'b0001;
      n = 2;
      tick();
      n++;
      while (req_ack == 4'b0000 && n < 30) begin
         tick();
         n++;
      end
`ifdef SEG_ARB_PREEMPT_EN
      chk("pe_latency", n, 32'd3);
`else
      chk("pe_latency", n, 32'd10);
`endif
      chk("pe_ack0", {28'd0, req_ack}, 32'h1);
      chk("pe_dsp",  dsp_data, 32'hFFFF_1234);
      chk("pe_gid",  {30'd0, grant_id}, 32'd0);
      req_valid = 4'b0000;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
